// File: rtl/mem_stall_responder.sv
`default_nettype none
// ============================================================================
// mem_stall_responder : word memory slave with grant stalls, credit-limited
//                       outstanding requests and a fixed-latency response pipe
// Revision: 1.0
// ============================================================================
module mem_stall_responder #(
    parameter int unsigned Depth          = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW    = $clog2(Depth);
    localparam logic [32:0] c_END = {1'b0, BaseAddr} + 33'(Depth) * 33'd4;

    logic [3:0]  stall_q, stall_d;
    logic [2:0]  outst_q, outst_d;
    logic        in_range;
    logic [AW-1:0] idx;

    logic [31:0] mem_q [Depth];

    logic [RespLatency-1:0] vld_q;
    logic [RespLatency-1:0] err_q;
    logic [31:0]            data_q [RespLatency];

    // BaseAddr is Depth*4 aligned, so the word index is a plain bit slice
    assign in_range = ({1'b0, addr_i} >= {1'b0, BaseAddr}) && ({1'b0, addr_i} < c_END);
    assign idx      = addr_i[AW+1:2];

    assign gnt_o = rst_ni && req_i && (stall_q == 4'(GntDelay))
                   && (outst_q < 3'(MaxOutstanding));

    always_comb begin
        stall_d = stall_q;
        if (!req_i || gnt_o) begin
            stall_d = '0;
        end else if (stall_q < 4'(GntDelay)) begin
            stall_d = stall_q + 4'd1;
        end
    end

    assign outst_d = outst_q + 3'(gnt_o) - 3'(rvalid_o);

    // Memory has no reset: contents survive rst_ni
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q   <= '0;
            outst_q   <= '0;
            vld_q[0]  <= 1'b0;
            err_q[0]  <= 1'b0;
            data_q[0] <= '0;
        end else begin
            stall_q   <= stall_d;
            outst_q   <= outst_d;
            vld_q[0]  <= gnt_o;
            err_q[0]  <= gnt_o && !in_range;
            data_q[0] <= (gnt_o && !we_i && in_range) ? mem_q[idx] : 32'h0;
        end
    end

    generate
        for (genvar i = 1; i < RespLatency; i++) begin : g_stage
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q[i]  <= 1'b0;
                    err_q[i]  <= 1'b0;
                    data_q[i] <= '0;
                end else begin
                    vld_q[i]  <= vld_q[i-1];
                    err_q[i]  <= err_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    endgenerate

    assign rvalid_o = vld_q[RespLatency-1];
    assign err_o    = err_q[RespLatency-1];
    assign rdata_o  = data_q[RespLatency-1];

endmodule
`default_nettype wire
